// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the credit-controlled fetch front end.
package fetch_queue_unit_pkg;

  localparam int PKG_XLEN = 32;
  localparam logic [PKG_XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Memory request/response, redirect and decode handshake bundle of the fetch unit.
interface fetch_queue_unit_if
  import fetch_queue_unit_pkg::*;
#(
  parameter int XLEN     = PKG_XLEN,
  parameter int FQ_DEPTH = 4
);
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus_4;
  logic [XLEN-1:0] out_inst;
  logic [CW-1:0]   fq_count;

  modport slave (
    output imem_req, imem_addr, out_valid, out_pc, out_pc_plus_4, out_inst, fq_count,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport master (
    input  imem_req, imem_addr, out_valid, out_pc, out_pc_plus_4, out_inst, fq_count,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// In-order queue of fetched {pc, inst} entries; synchronous clear wins over push.
module fetch_queue_unit_fifo
  import fetch_queue_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The issue credit makes a push into a full, non-draining queue impossible.
  always @(posedge clk) begin
    if (rst_n && !clr) assert (!(push && full && !do_pop));
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC register, in-flight latency pipe and credit-gated issue feeding the fetch queue.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int              XLEN         = PKG_XLEN,
  parameter int              FQ_DEPTH     = 4,
  parameter int              IMEM_LATENCY = 1,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter logic [XLEN-1:0] NOP_INST     = DEFAULT_NOP_INST
) (
  input logic               clk,
  input logic               reset_n,
  fetch_queue_unit_if.slave bus
);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int SW = 16;

  logic [IMEM_LATENCY-1:0] slot_v_q, slot_v_d;
  logic [XLEN-1:0]         slot_pc_q [IMEM_LATENCY];
  logic [XLEN-1:0]         slot_pc_d [IMEM_LATENCY];
  logic [XLEN-1:0]         fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]         last_pc_q, last_pc_d;
  logic [SW-1:0]           inflight, credit_use;
  logic                    issue, pop, push, fifo_empty;
  logic [CW-1:0]           count;
  fetch_entry_t            head, ret_entry;
  logic [XLEN-1:0]         out_pc;

  assign pop       = !fifo_empty && bus.out_ready;
  assign push      = slot_v_q[IMEM_LATENCY-1];
  assign ret_entry = '{pc: slot_pc_q[IMEM_LATENCY-1], inst: bus.imem_rdata};

  fetch_queue_unit_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .clr       (bus.redirect_valid),
    .push      (push),
    .push_data (ret_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty)
  );

  always_comb begin
    inflight = '0;
    for (int i = 0; i < IMEM_LATENCY; i++) inflight = inflight + SW'(slot_v_q[i]);
    // Queued + in-flight - leaving this cycle must stay below depth for a new request.
    credit_use = SW'(count) + inflight - SW'(pop);
    issue      = reset_n && !bus.redirect_valid && (credit_use < SW'(FQ_DEPTH));

    slot_v_d[0]  = issue;
    slot_pc_d[0] = fetch_pc_q;
    for (int i = 1; i < IMEM_LATENCY; i++) begin
      slot_v_d[i]  = slot_v_q[i-1] && !bus.redirect_valid;
      slot_pc_d[i] = slot_pc_q[i-1];
    end

    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc;
    else if (issue)         fetch_pc_d = fetch_pc_q + XLEN'(4);

    last_pc_d = fifo_empty ? last_pc_q : head.pc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_v_q <= '0;
      for (int i = 0; i < IMEM_LATENCY; i++) slot_pc_q[i] <= '0;
      fetch_pc_q <= RESET_PC;
      last_pc_q  <= RESET_PC;
    end else begin
      slot_v_q   <= slot_v_d;
      slot_pc_q  <= slot_pc_d;
      fetch_pc_q <= fetch_pc_d;
      last_pc_q  <= last_pc_d;
    end
  end

  assign out_pc            = fifo_empty ? last_pc_q : head.pc;
  assign bus.imem_req      = issue;
  assign bus.imem_addr     = fetch_pc_q;
  assign bus.out_valid     = !fifo_empty;
  assign bus.out_pc        = out_pc;
  assign bus.out_pc_plus_4 = out_pc + XLEN'(4);
  assign bus.out_inst      = fifo_empty ? NOP_INST : head.inst;
  assign bus.fq_count      = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: cycle table on a latency-1 unit plus a streaming latency-3 unit, both scoreboarded.
module tb_fetch_queue_unit;
  import fetch_queue_unit_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_unit_if #(.XLEN(32), .FQ_DEPTH(4)) bus1 ();
  fetch_queue_unit_if #(.XLEN(32), .FQ_DEPTH(4)) bus3 ();

  fetch_queue_unit #(.XLEN(32), .FQ_DEPTH(4), .IMEM_LATENCY(1),
                     .RESET_PC(32'h0), .NOP_INST(32'h13)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));
  fetch_queue_unit #(.XLEN(32), .FQ_DEPTH(4), .IMEM_LATENCY(3),
                     .RESET_PC(32'h0), .NOP_INST(32'h13)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3));

  // Instruction memories: data = addr ^ KEY, delivered after the configured latency.
  logic [31:0] mem1_q = '0;
  logic [31:0] mem3_q [3] = '{32'h0, 32'h0, 32'h0};
  always @(posedge clk) begin
    mem1_q    <= bus1.imem_addr;
    mem3_q[0] <= bus3.imem_addr;
    mem3_q[1] <= mem3_q[0];
    mem3_q[2] <= mem3_q[1];
  end
  assign bus1.imem_rdata = mem1_q ^ KEY;
  assign bus3.imem_rdata = mem3_q[2] ^ KEY;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  function automatic vec_t mk(logic rdy, logic redir, logic [31:0] rpc, logic req,
                              logic [31:0] addr, logic vld, logic [31:0] pc, logic [2:0] cnt);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.req = req;
    v.addr = addr; v.vld = vld; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  vec_t vt [28];

  // Scoreboard for the latency-1 unit.
  logic [31:0] exp_q1 [$];
  logic [31:0] exp_pc1, e1;
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q1.delete();
      exp_pc1 = 32'h0;
    end else begin
      if (bus1.out_valid && bus1.out_ready) begin
        if (exp_q1.size() == 0) chk("sb1_unexpected_pop", 32'h1, 32'h0);
        else begin
          e1 = exp_q1.pop_front();
          chk("sb1_pc", bus1.out_pc, e1);
          chk("sb1_inst", bus1.out_inst, e1 ^ KEY);
          chk("sb1_pc4", bus1.out_pc_plus_4, e1 + 32'd4);
        end
      end
      if (bus1.redirect_valid) begin
        exp_q1.delete();
        exp_pc1 = bus1.redirect_pc;
      end else if (bus1.imem_req) begin
        chk("sb1_addr", bus1.imem_addr, exp_pc1);
        exp_q1.push_back(exp_pc1);
        exp_pc1 = exp_pc1 + 32'd4;
      end
    end
  end

  // Scoreboard and throughput checks for the latency-3 unit (always ready, never redirected).
  logic [31:0] exp_q3 [$];
  logic [31:0] exp_pc3, e3;
  logic [2:0]  hist3;
  int          cyc3;
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q3.delete();
      exp_pc3 = 32'h0;
      hist3   = '0;
      cyc3    = 0;
    end else begin
      if (bus3.out_valid && bus3.out_ready) begin
        if (exp_q3.size() == 0) chk("sb3_unexpected_pop", 32'h1, 32'h0);
        else begin
          e3 = exp_q3.pop_front();
          chk("sb3_pc", bus3.out_pc, e3);
          chk("sb3_inst", bus3.out_inst, e3 ^ KEY);
        end
      end
      chk("l3_req", 32'(bus3.imem_req), 32'h1);
      chk("l3_valid", 32'(bus3.out_valid), 32'(cyc3 >= 4));
      if (cyc3 >= 4) chk("l3_count", 32'(bus3.fq_count), 32'h1);
      chk("l3_credit", 32'((32'(bus3.fq_count) + 32'(hist3[0]) + 32'(hist3[1]) + 32'(hist3[2])) <= 32'd4), 32'h1);
      if (bus3.imem_req) begin
        chk("sb3_addr", bus3.imem_addr, exp_pc3);
        exp_q3.push_back(exp_pc3);
        exp_pc3 = exp_pc3 + 32'd4;
      end
      hist3 = {hist3[1:0], bus3.imem_req};
      cyc3++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            rdy redir rpc           req addr          vld pc            cnt
    vt[0]  = mk(1, 0, 32'h0,   1, 32'h000, 0, 32'h000, 3'd0);
    vt[1]  = mk(1, 0, 32'h0,   1, 32'h004, 0, 32'h000, 3'd0);
    vt[2]  = mk(1, 0, 32'h0,   1, 32'h008, 1, 32'h000, 3'd1);
    vt[3]  = mk(1, 0, 32'h0,   1, 32'h00C, 1, 32'h004, 3'd1);
    vt[4]  = mk(0, 0, 32'h0,   1, 32'h010, 1, 32'h008, 3'd1);
    vt[5]  = mk(0, 0, 32'h0,   1, 32'h014, 1, 32'h008, 3'd2);
    vt[6]  = mk(0, 0, 32'h0,   0, 32'h000, 1, 32'h008, 3'd3);
    vt[7]  = mk(0, 0, 32'h0,   0, 32'h000, 1, 32'h008, 3'd4);
    vt[8]  = mk(0, 0, 32'h0,   0, 32'h000, 1, 32'h008, 3'd4);
    vt[9]  = mk(1, 0, 32'h0,   1, 32'h018, 1, 32'h008, 3'd4);
    vt[10] = mk(1, 0, 32'h0,   1, 32'h01C, 1, 32'h00C, 3'd3);
    vt[11] = mk(0, 1, 32'h100, 0, 32'h000, 1, 32'h010, 3'd3);
    vt[12] = mk(1, 0, 32'h0,   1, 32'h100, 0, 32'h010, 3'd0);
    vt[13] = mk(1, 0, 32'h0,   1, 32'h104, 0, 32'h010, 3'd0);
    vt[14] = mk(1, 0, 32'h0,   1, 32'h108, 1, 32'h100, 3'd1);
    vt[15] = mk(1, 1, 32'h200, 0, 32'h000, 1, 32'h104, 3'd1);
    vt[16] = mk(1, 0, 32'h0,   1, 32'h200, 0, 32'h104, 3'd0);
    vt[17] = mk(1, 0, 32'h0,   1, 32'h204, 0, 32'h104, 3'd0);
    vt[18] = mk(1, 0, 32'h0,   1, 32'h208, 1, 32'h200, 3'd1);
    vt[19] = mk(1, 1, 32'h300, 0, 32'h000, 1, 32'h204, 3'd1);
    vt[20] = mk(1, 1, 32'h400, 0, 32'h000, 0, 32'h204, 3'd0);
    vt[21] = mk(1, 0, 32'h0,   1, 32'h400, 0, 32'h204, 3'd0);
    vt[22] = mk(1, 0, 32'h0,   1, 32'h404, 0, 32'h204, 3'd0);
    vt[23] = mk(1, 1, 32'h502, 0, 32'h000, 1, 32'h400, 3'd1);
    vt[24] = mk(1, 0, 32'h0,   1, 32'h502, 0, 32'h400, 3'd0);
    vt[25] = mk(1, 0, 32'h0,   1, 32'h506, 0, 32'h400, 3'd0);
    vt[26] = mk(1, 0, 32'h0,   1, 32'h50A, 1, 32'h502, 3'd1);
    vt[27] = mk(1, 0, 32'h0,   1, 32'h50E, 1, 32'h506, 3'd1);

    bus1.out_ready = 1'b1; bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0;
    bus3.out_ready = 1'b1; bus3.redirect_valid = 1'b0; bus3.redirect_pc = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus1.out_valid), 32'h0);
    chk("rst_req", 32'(bus1.imem_req), 32'h0);
    chk("rst_count", 32'(bus1.fq_count), 32'h0);
    chk("rst_inst", bus1.out_inst, NOP);

    for (int i = 0; i < 28; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) reset_n = 1'b1;
      bus1.out_ready      = vt[i].rdy;
      bus1.redirect_valid = vt[i].redir;
      bus1.redirect_pc    = vt[i].rpc;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), 32'(bus1.imem_req), 32'(vt[i].req));
      if (vt[i].req) chk($sformatf("v%0d_addr", i), bus1.imem_addr, vt[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(bus1.out_valid), 32'(vt[i].vld));
      chk($sformatf("v%0d_count", i), 32'(bus1.fq_count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_pc", i), bus1.out_pc, vt[i].pc);
      chk($sformatf("v%0d_pc4", i), bus1.out_pc_plus_4, vt[i].pc + 32'd4);
      chk($sformatf("v%0d_inst", i), bus1.out_inst, vt[i].vld ? (vt[i].pc ^ KEY) : NOP);
    end

    @(posedge clk);
    #1;
    bus1.out_ready = 1'b1; bus1.redirect_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of streaming with requests in flight.
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid1", 32'(bus1.out_valid), 32'h0);
    chk("mid_rst_count1", 32'(bus1.fq_count), 32'h0);
    chk("mid_rst_req1", 32'(bus1.imem_req), 32'h0);
    chk("mid_rst_inst1", bus1.out_inst, NOP);
    chk("mid_rst_valid3", 32'(bus3.out_valid), 32'h0);
    chk("mid_rst_count3", 32'(bus3.fq_count), 32'h0);
    chk("mid_rst_req3", 32'(bus3.imem_req), 32'h0);
    chk("mid_rst_inst3", bus3.out_inst, NOP);

    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("restart_req", 32'(bus1.imem_req), 32'h1);
    chk("restart_addr", bus1.imem_addr, 32'h0);
    chk("restart_valid0", 32'(bus1.out_valid), 32'h0);
    @(negedge clk);
    chk("restart_valid1", 32'(bus1.out_valid), 32'h0);
    @(negedge clk);
    chk("restart_valid2", 32'(bus1.out_valid), 32'h1);
    chk("restart_pc", bus1.out_pc, 32'h0);
    chk("restart_inst", bus1.out_inst, KEY);

    repeat (10) @(negedge clk);
    chk("l3_sb_depth", 32'(exp_q3.size()), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
